fp_div_seq: RTL and testbench
=============================

// Module: fp_div_seq
// PURPOSE
//  Sequencer around the iterative fixed-point mantissa divider (div): unpacks two IEEE-754 operands,
//  short-circuits special cases, issues hidden-bit mantissas to the divider, then normalises,
//  rounds (RNE) and packs the quotient. Sits between the FPU issue stage and div.
// PARAMETERS
//  EXP  8   exponent bits
//  MANT 23  stored mantissa bits; FB=MANT+3 divider fractional bits, DW=FB+2 divider width
// PORTS
//  clk        in  1          clock
//  rst_n      in  1          synchronous active-low reset
//  in_valid   in  1          operand pair valid
//  in_ready   out 1          high only in IDLE
//  a, b       in  EXP+MANT+1 dividend, divisor
//  out_valid  out 1          result valid
//  out_ready  in  1          consumer accepts result
//  result     out EXP+MANT+1 packed quotient
//  flags      out 5          {nv,dz,of,uf,nx}
//  div_start  out 1          1-cycle start pulse to divider
//  div_x,div_y out DW        fixed-point operands {2'b01,mant,3'b000}
//  div_busy,div_valid,div_dbz,div_ovf in 1  divider status
//  div_q,div_r in DW         divider quotient, remainder
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE; out_valid,div_start,result,flags=0; in_ready=1.
//  Reset mid-operation abandons the op; the divider is not reset, and the next div_start restarts it.
//  Handshake: accept on in_valid&in_ready; result/flags stable while out_valid&!out_ready.
//  FSM: IDLE -accept,special-> OUT; IDLE -accept,normal-> ISSUE; ISSUE (div_start=1) -> WAIT;
//   WAIT -div_valid-> NORM; NORM -> OUT; OUT -out_ready-> IDLE. No other transitions.
//  Unpack: exp=0 -> zero (subnormals flushed, sign kept); exp=all-1s -> inf/NaN. sign=sa^sb.
//  Specials (priority order): any NaN, 0/0, inf/inf -> 0x7FC.. canonical qNaN, nv;
//   inf/x -> inf; x/0 -> inf, dz; 0/x or x/inf -> signed zero. No flags unless stated.
//  Latency: special = 1 cycle accept->out_valid. Normal = 3 cycles + divider time
//   (ISSUE, WAIT>=1 cycle, NORM).
//  Normalise: q in (0.5,2). q[FB]=1 -> m=q[FB-1 -: MANT], guard/round below, e=ea-eb+BIAS.
//   Else shift q left by 1, e=ea-eb+BIAS-1. e is computed signed, width EXP+2.
//  Sticky = OR(dropped q bits) | (div_r!=0). nx = guard|sticky.
//  RNE: increment when guard & (round|sticky|lsb). A mantissa carry-out increments e.
//  After rounding: e>=2^EXP-1 -> signed inf, of+nx. e<=0 -> signed zero, uf+nx (no subnormals).
//  div_dbz cannot occur. div_ovf must never occur; if either is seen, the result is qNaN with nv.
//  div_start is asserted only in ISSUE. div_x/div_y are registered at accept.
//  in_valid is ignored outside IDLE.
// TESTING
//  6.0/2.0: a=0x40C00000 b=0x40000000 -> result 0x40400000, flags 0.
//  1.0/3.0: 0x3F800000/0x40400000 -> 0x3EAAAAAB, flags nx only.
//  1.0/0: 0x3F800000/0x00000000 -> 0x7F800000, dz; out_valid 1 cycle after accept, div_start never set.
//  0/0 and inf/inf -> 0x7FC00000, nv. -2.0/inf (0xC0000000/0x7F800000) -> 0x80000000.
//  max/0.5: 0x7F7FFFFF/0x3F000000 -> 0x7F800000, of|nx. 2^-126/4.0 -> 0x00000000, uf|nx.
//  Back-pressure and reset: hold out_ready=0 for 3 cycles -> result stable, in_ready=0.
//   Drop rst_n during WAIT -> IDLE next cycle with out_valid=0, and the next op completes correctly.

Source files
------------

// File: rtl/fp_div_seq.sv
// Sequencer for single-cycle-issue IEEE-754 division around an external iterative mantissa divider.
// Unpacks the operands, resolves special cases locally, then normalises, rounds (RNE) and packs the quotient.
module fp_div_seq #(
    parameter int EXP = 8,
    parameter int MANT = 23,
    localparam int FB = MANT + 3,
    localparam int DW = FB + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXP+MANT:0] a,
    input  logic [EXP+MANT:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP+MANT:0] result,
    output logic [4:0]        flags,
    output logic              div_start,
    output logic [DW-1:0]     div_x,
    output logic [DW-1:0]     div_y,
    input  logic              div_busy,
    input  logic              div_valid,
    input  logic              div_dbz,
    input  logic              div_ovf,
    input  logic [DW-1:0]     div_q,
    input  logic [DW-1:0]     div_r
);
    localparam int W  = EXP + MANT + 1;
    localparam int EW = EXP + 2;
    localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP) - 1);
    localparam logic signed [EW-1:0] ONE   = EW'(1);
    localparam logic signed [EW-1:0] ZERO  = '0;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP{1'b1}}, 1'b1, {(MANT-1){1'b0}}};
    localparam logic [4:0] F_NV = 5'b10000;
    localparam logic [4:0] F_DZ = 5'b01000;
    localparam logic [4:0] F_OF = 5'b00100;
    localparam logic [4:0] F_UF = 5'b00010;
    localparam logic [4:0] F_NX = 5'b00001;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NORM, S_OUT} state_t;

    state_t                 state_q, state_d;
    logic [W-1:0]           result_q, result_d;
    logic [4:0]             flags_q, flags_d;
    logic [DW-1:0]          div_x_q, div_y_q, q_q;
    logic signed [EW-1:0]   exp_q;
    logic                   sign_q, rnz_q, err_q;

    // Returns {carry, mantissa}; round-half-even with round bit folded into sticky.
    function automatic logic [MANT:0] round_rne(input logic [MANT-1:0] m, input logic g,
                                                input logic s);
        return {1'b0, m} + (MANT+1)'(g & (s | m[0]));
    endfunction

    logic [EXP-1:0]  ea, eb;
    logic [MANT-1:0] ma, mb;
    logic            a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special, sign;
    logic [W-1:0]    spec_res;
    logic [4:0]      spec_flg;

    assign ea      = a[W-2 -: EXP];
    assign eb      = b[W-2 -: EXP];
    assign ma      = a[MANT-1:0];
    assign mb      = b[MANT-1:0];
    assign a_zero  = (ea == '0);
    assign b_zero  = (eb == '0);
    assign a_inf   = (&ea) && (ma == '0);
    assign b_inf   = (&eb) && (mb == '0);
    assign a_nan   = (&ea) && (ma != '0);
    assign b_nan   = (&eb) && (mb != '0);
    assign special = a_zero | b_zero | (&ea) | (&eb);
    assign sign    = a[W-1] ^ b[W-1];

    always_comb begin
        spec_res = {sign, {(W-1){1'b0}}};
        spec_flg = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res = QNAN;
            spec_flg = F_NV;
        end else if (a_inf) begin
            spec_res = {sign, {EXP{1'b1}}, {MANT{1'b0}}};
        end else if (b_zero) begin
            spec_res = {sign, {EXP{1'b1}}, {MANT{1'b0}}};
            spec_flg = F_DZ;
        end
    end

    logic [MANT-1:0]      m_pre;
    logic [MANT:0]        m_rnd;
    logic                 g, st;
    logic signed [EW-1:0] e_pre, e_rnd;
    logic [W-1:0]         norm_res;
    logic [4:0]           norm_flg;

    // Quotient lies in (0.5,2): either the integer bit is set or one left shift normalises it.
    always_comb begin
        if (q_q[FB]) begin
            m_pre = q_q[FB-1 -: MANT];
            g     = q_q[FB-MANT-1];
            st    = (|q_q[FB-MANT-2:0]) | rnz_q;
            e_pre = exp_q;
        end else begin
            m_pre = q_q[FB-2 -: MANT];
            g     = q_q[FB-MANT-2];
            st    = (|q_q[FB-MANT-3:0]) | rnz_q;
            e_pre = exp_q - ONE;
        end
        m_rnd    = round_rne(m_pre, g, st);
        e_rnd    = e_pre + (m_rnd[MANT] ? ONE : ZERO);
        norm_res = {sign_q, e_rnd[EXP-1:0], m_rnd[MANT-1:0]};
        norm_flg = (g | st) ? F_NX : 5'b0;
        if (err_q) begin
            norm_res = QNAN;
            norm_flg = F_NV;
        end else if (e_rnd >= EMAX) begin
            norm_res = {sign_q, {EXP{1'b1}}, {MANT{1'b0}}};
            norm_flg = F_OF | F_NX;
        end else if (e_rnd <= ZERO) begin
            norm_res = {sign_q, {(W-1){1'b0}}};
            norm_flg = F_UF | F_NX;
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (special) begin
                        state_d  = S_OUT;
                        result_d = spec_res;
                        flags_d  = spec_flg;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (div_valid) state_d = S_NORM;
            S_NORM: begin
                state_d  = S_OUT;
                result_d = norm_res;
                flags_d  = norm_flg;
            end
            S_OUT:   if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    // Operand and divider-result capture; the divider itself is never reset from here.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && in_valid) begin
            div_x_q <= {2'b01, ma, 3'b000};
            div_y_q <= {2'b01, mb, 3'b000};
            exp_q   <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
            sign_q  <= sign;
        end
        if (state_q == S_WAIT && div_valid) begin
            q_q   <= div_q;
            rnz_q <= |div_r;
            err_q <= div_dbz | div_ovf;
        end
    end

    logic unused_sig;
    assign unused_sig = ^{div_busy, q_q[DW-1]};

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign div_start = (state_q == S_ISSUE);
    assign div_x     = div_x_q;
    assign div_y     = div_y_q;
    assign result    = result_q;
    assign flags     = flags_q;
endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq with a behavioural fixed-latency mantissa divider.
module tb_fp_div_seq;
    localparam int DW   = 28;
    localparam int FB   = 26;
    localparam int DLAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid, div_start;
    logic [31:0] result;
    logic [4:0]  flags;
    logic [DW-1:0] div_x, div_y;
    logic        div_busy = 1'b0, div_valid = 1'b0, div_dbz = 1'b0, div_ovf = 1'b0;
    logic [DW-1:0] div_q = '0, div_r = '0;
    logic        inject_ovf = 1'b0;
    int          starts = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    fp_div_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .div_start(div_start),
        .div_x(div_x), .div_y(div_y), .div_busy(div_busy), .div_valid(div_valid),
        .div_dbz(div_dbz), .div_ovf(div_ovf), .div_q(div_q), .div_r(div_r)
    );

    always #5 clk = ~clk;

    // Divider model: q = x / y with FB fractional bits, result DLAT+1 edges after start.
    logic [DW-1:0] mx = '0, my = '0;
    int            mcnt = 0;
    logic [DW+FB-1:0] num, den;
    always_comb begin
        num = {mx, {FB{1'b0}}};
        den = {{FB{1'b0}}, my};
    end
    always @(posedge clk) begin
        div_valid <= 1'b0;
        div_ovf   <= 1'b0;
        if (div_start) begin
            starts   <= starts + 1;
            mx       <= div_x;
            my       <= div_y;
            div_busy <= 1'b1;
            mcnt     <= DLAT;
        end else if (div_busy) begin
            if (mcnt == 1) begin
                div_busy  <= 1'b0;
                div_valid <= 1'b1;
                div_q     <= DW'(num / den);
                div_r     <= DW'(num % den);
                div_ovf   <= inject_ovf;
            end else begin
                mcnt <= mcnt - 1;
            end
        end
    end

    // Vectors: {a, b, result, flags}
    logic [31:0] nm_a [6] = '{32'h40C00000, 32'h3F800000, 32'hC0C00000, 32'h40400000, 32'h3F800000, 32'hBF800000};
    logic [31:0] nm_b [6] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h3FC00000, 32'h3FC00000, 32'h40400000};
    logic [31:0] nm_r [6] = '{32'h40400000, 32'h3EAAAAAB, 32'hC0400000, 32'h40000000, 32'h3F2AAAAB, 32'hBEAAAAAB};
    logic [4:0]  nm_f [6] = '{5'h00, 5'h01, 5'h00, 5'h00, 5'h01, 5'h01};

    logic [31:0] sp_a [8] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'hC0000000, 32'h7FC00001, 32'h7F800000, 32'h00000001, 32'h3F800000};
    logic [31:0] sp_b [8] = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'h7F800000, 32'h3F800000, 32'hC0000000, 32'h3F800000, 32'hFF800000};
    logic [31:0] sp_r [8] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h80000000, 32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h80000000};
    logic [4:0]  sp_f [8] = '{5'h08, 5'h10, 5'h10, 5'h00, 5'h10, 5'h00, 5'h00, 5'h00};

    logic [31:0] rg_a [2] = '{32'h7F7FFFFF, 32'h00800000};
    logic [31:0] rg_b [2] = '{32'h3F000000, 32'h40800000};
    logic [31:0] rg_r [2] = '{32'h7F800000, 32'h00000000};
    logic [4:0]  rg_f [2] = '{5'h05, 5'h03};

    // Entered #1 after an edge with the DUT idle; lat counts edges from accept to out_valid.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, output logic [31:0] res,
                          output logic [4:0] flg, output int lat, output int nst);
        int s0;
        s0 = starts;
        a = ta;
        b = tbv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            n_checks++; n_fail++;
            $display("FAIL timeout a=%h b=%h: out_valid never rose", ta, tbv);
        end
        res = result;
        flg = flags;
        nst = starts - s0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
        n_checks++; if (flags !== 5'h0) begin n_fail++; $display("FAIL reset_flags got %h want 0", flags); end
        n_checks++; if (div_start !== 1'b0) begin n_fail++; $display("FAIL reset_div_start got %b want 0", div_start); end
        rst_n = 1'b1;
    endtask

    // Normal path latency: ISSUE + WAIT (DLAT+1) + NORM, counted inclusive of the accept edge.
    task automatic test_normal;
        logic [31:0] r; logic [4:0] f; int lat, nst;
        for (int i = 0; i < 6; i++) begin
            run_op(nm_a[i], nm_b[i], r, f, lat, nst);
            n_checks++; if (r !== nm_r[i]) begin n_fail++; $display("FAIL normal_result[%0d] got %h want %h", i, r, nm_r[i]); end
            n_checks++; if (f !== nm_f[i]) begin n_fail++; $display("FAIL normal_flags[%0d] got %h want %h", i, f, nm_f[i]); end
            n_checks++; if (lat != DLAT + 4) begin n_fail++; $display("FAIL normal_latency[%0d] got %0d want %0d", i, lat, DLAT + 4); end
            n_checks++; if (nst != 1) begin n_fail++; $display("FAIL normal_starts[%0d] got %0d want 1", i, nst); end
        end
    endtask

    task automatic test_special;
        logic [31:0] r; logic [4:0] f; int lat, nst;
        for (int i = 0; i < 8; i++) begin
            run_op(sp_a[i], sp_b[i], r, f, lat, nst);
            n_checks++; if (r !== sp_r[i]) begin n_fail++; $display("FAIL special_result[%0d] got %h want %h", i, r, sp_r[i]); end
            n_checks++; if (f !== sp_f[i]) begin n_fail++; $display("FAIL special_flags[%0d] got %h want %h", i, f, sp_f[i]); end
            n_checks++; if (lat != 1) begin n_fail++; $display("FAIL special_latency[%0d] got %0d want 1", i, lat); end
            n_checks++; if (nst != 0) begin n_fail++; $display("FAIL special_starts[%0d] got %0d want 0", i, nst); end
        end
    endtask

    task automatic test_range;
        logic [31:0] r; logic [4:0] f; int lat, nst;
        for (int i = 0; i < 2; i++) begin
            run_op(rg_a[i], rg_b[i], r, f, lat, nst);
            n_checks++; if (r !== rg_r[i]) begin n_fail++; $display("FAIL range_result[%0d] got %h want %h", i, r, rg_r[i]); end
            n_checks++; if (f !== rg_f[i]) begin n_fail++; $display("FAIL range_flags[%0d] got %h want %h", i, f, rg_f[i]); end
        end
    endtask

    task automatic test_backpressure;
        int n;
        a = 32'h40C00000;
        b = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'h3F800000;
        b = 32'h00000000;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d] got %b want 1", i, out_valid); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
            n_checks++; if (result !== 32'h40400000) begin n_fail++; $display("FAIL bp_result[%0d] got %h want 40400000", i, result); end
            n_checks++; if (flags !== 5'h00) begin n_fail++; $display("FAIL bp_flags[%0d] got %h want 00", i, flags); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r; logic [4:0] f; int lat, nst;
        a = 32'h3F800000;
        b = 32'h40400000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_checks++; if (div_busy !== 1'b1) begin n_fail++; $display("FAIL mid_not_waiting got busy=%b want 1", div_busy); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_in_ready got %b want 1", in_ready); end
        run_op(32'h40C00000, 32'h40000000, r, f, lat, nst);
        n_checks++; if (r !== 32'h40400000) begin n_fail++; $display("FAIL mid_next_result got %h want 40400000", r); end
        n_checks++; if (f !== 5'h00) begin n_fail++; $display("FAIL mid_next_flags got %h want 00", f); end
        n_checks++; if (nst != 1) begin n_fail++; $display("FAIL mid_next_starts got %0d want 1", nst); end
    endtask

    task automatic test_div_ovf;
        logic [31:0] r; logic [4:0] f; int lat, nst;
        inject_ovf = 1'b1;
        run_op(32'h40C00000, 32'h40000000, r, f, lat, nst);
        inject_ovf = 1'b0;
        n_checks++; if (r !== 32'h7FC00000) begin n_fail++; $display("FAIL ovf_result got %h want 7fc00000", r); end
        n_checks++; if (f !== 5'h10) begin n_fail++; $display("FAIL ovf_flags got %h want 10", f); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_range();
        test_backpressure();
        test_reset_mid();
        test_div_ovf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
